// File: rtl/m_ext_wb_arb_pkg.sv
// Shared types for the M-extension writeback arbiter: the EXE/MEM pipelined-signal bundle,
// the writeback source tag and the buffered result entry.
package m_ext_wb_arb_pkg;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_we;
    logic [1:0] wb_sel;
  } exe_p_mux_bus_type;

  typedef enum logic {
    SRC_MUL = 1'b0,
    SRC_DIV = 1'b1
  } m_wb_src_t;

  typedef struct packed {
    exe_p_mux_bus_type pipe;
    logic [31:0]       result;
  } m_wb_entry_t;

endpackage

// File: rtl/m_ext_wb_arb_if.sv
// Result-stream bundle between int_mul, the divider, the arbiter and the EXE/MEM mux.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface m_ext_wb_arb_if;
  import m_ext_wb_arb_pkg::*;

  logic              mul_valid;
  exe_p_mux_bus_type mul_pipe;
  logic [31:0]       mul_result;
  logic              mul_stall;

  logic              div_valid;
  exe_p_mux_bus_type div_pipe;
  logic [31:0]       div_result;
  logic              div_ready;

  logic              wb_valid;
  logic              wb_ready;
  exe_p_mux_bus_type wb_pipe;
  logic [31:0]       wb_result;
  m_wb_src_t         wb_src;
  logic              busy;

  modport slave (
    input  mul_valid, mul_pipe, mul_result, div_valid, div_pipe, div_result, wb_ready,
    output mul_stall, div_ready, wb_valid, wb_pipe, wb_result, wb_src, busy
  );

  modport master (
    output mul_valid, mul_pipe, mul_result, div_valid, div_pipe, div_result, wb_ready,
    input  mul_stall, div_ready, wb_valid, wb_pipe, wb_result, wb_src, busy
  );
endinterface

// File: rtl/m_ext_res_fifo.sv
// Small FIFO holding multiplier results while the writeback slot is busy.
// Push is ignored when full, pop when empty; flush empties it at the next edge.
module m_ext_res_fifo
  import m_ext_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  m_wb_entry_t                  push_data,
  input  logic                         pop,
  output m_wb_entry_t                  pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  m_wb_entry_t     mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/m_ext_wb_arb.sv
// Completion arbiter behind int_mul: merges buffered multiplier results and the divider's
// valid/ready stream into one registered writeback slot, with divider anti-starvation.
module m_ext_wb_arb
  import m_ext_wb_arb_pkg::*;
#(
  parameter int unsigned MUL_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  m_ext_wb_arb_if.slave  bus
);
  localparam int unsigned CntW = $clog2(MUL_FIFO_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  m_wb_entry_t     head;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            load, div_force, sel_div, sel_mul;

  logic            wb_valid_q;
  m_wb_entry_t     wb_entry_q;
  m_wb_src_t       wb_src_q;
  logic [StW-1:0]  starve_q;

  m_ext_res_fifo #(
    .DEPTH(MUL_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (bus.mul_valid),
    .push_data ('{pipe: bus.mul_pipe, result: bus.mul_result}),
    .pop       (sel_mul),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Slot arbitration: a starved divider result beats the FIFO head, otherwise mul first.
  always_comb begin
    load      = !wb_valid_q || bus.wb_ready;
    div_force = bus.div_valid && (starve_q == StW'(STARVE_LIMIT));
    sel_div   = 1'b0;
    sel_mul   = 1'b0;
    if (load && !flush) begin
      if (div_force)          sel_div = 1'b1;
      else if (!empty)        sel_mul = 1'b1;
      else if (bus.div_valid) sel_div = 1'b1;
    end
  end

  // Stall comes from registered occupancy only, so int_mul never sees a wb_ready path.
  assign bus.mul_stall = full;
  // Gated by reset_n so the handshake output reads 0 the moment reset asserts.
  assign bus.div_ready = sel_div && reset_n;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_pipe   = wb_entry_q.pipe;
  assign bus.wb_result = wb_entry_q.result;
  assign bus.wb_src    = wb_src_q;
  assign bus.busy      = (count != '0) || wb_valid_q;

  // Writeback slot: reload whenever empty or drained, otherwise hold stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_entry_q <= '0;
      wb_src_q   <= SRC_MUL;
    end else if (flush) begin
      wb_valid_q <= 1'b0;
    end else if (load) begin
      wb_valid_q <= sel_div || sel_mul;
      if (sel_div) begin
        wb_entry_q <= '{pipe: bus.div_pipe, result: bus.div_result};
        wb_src_q   <= SRC_DIV;
      end else if (sel_mul) begin
        wb_entry_q <= head;
        wb_src_q   <= SRC_MUL;
      end
    end
  end

  // Count consecutive cycles a waiting divider result is refused, saturating at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (flush) begin
      starve_q <= '0;
    end else if (bus.div_valid && !sel_div) begin
      if (starve_q != StW'(STARVE_LIMIT)) starve_q <= starve_q + StW'(1);
    end else begin
      starve_q <= '0;
    end
  end

endmodule

// File: tb/tb_m_ext_wb_arb.sv
// Self-checking bench for m_ext_wb_arb: directed table, corner sequences and random traffic,
// all checked every cycle against a queue-based reference model.
module tb_m_ext_wb_arb;
  import m_ext_wb_arb_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned Limit = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  m_ext_wb_arb_if bus ();

  m_ext_wb_arb #(
    .MUL_FIFO_DEPTH(Depth),
    .STARVE_LIMIT  (Limit)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  m_wb_entry_t mq[$];
  logic        s_valid;
  m_wb_entry_t s_ent;
  logic        s_src;
  int          starve;

  // Results observed leaving the slot (valid && ready), in order.
  logic [31:0] acc[$];
  logic        acc_src[$];

  typedef struct {
    logic        mv;
    logic [31:0] mres;
    logic [4:0]  mrd;
    logic        dv;
    logic [31:0] dres;
    logic [4:0]  drd;
    logic        e_valid;
    logic [31:0] e_res;
    logic        e_src;
    logic [4:0]  e_rd;
    logic        e_dr;
    logic        e_busy;
  } vec_t;

  vec_t tbl[12];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exe_p_mux_bus_type pipe_of(input logic [4:0] rd);
    exe_p_mux_bus_type p;
    p.rd     = rd;
    p.rd_we  = 1'b1;
    p.wb_sel = rd[1:0];
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    s_valid = 1'b0;
    s_ent   = '0;
    s_src   = 1'b0;
    starve  = 0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input logic mv, input logic [31:0] mres, input exe_p_mux_bus_type mp,
                       input logic dv, input logic [31:0] dres, input exe_p_mux_bus_type dp,
                       input logic rdy, input logic fl,
                       output logic mul_taken, output logic div_taken);
    logic        exp_stall, ld, take_mul, take_div;
    m_wb_entry_t e;
    @(negedge clk);
    bus.mul_valid  = mv;
    bus.mul_result = mres;
    bus.mul_pipe   = mp;
    bus.div_valid  = dv;
    bus.div_result = dres;
    bus.div_pipe   = dp;
    bus.wb_ready   = rdy;
    flush          = fl;
    #1;
    exp_stall = (mq.size() == Depth);
    ld        = !s_valid || rdy;
    take_mul  = 1'b0;
    take_div  = 1'b0;
    if (!fl && ld) begin
      if (dv && starve == Limit) take_div = 1'b1;
      else if (mq.size() != 0)   take_mul = 1'b1;
      else if (dv)               take_div = 1'b1;
    end
    chk("mul_stall", bus.mul_stall, exp_stall);
    chk("div_ready", bus.div_ready, take_div);
    chk("wb_valid", bus.wb_valid, s_valid);
    chk("busy", bus.busy, (mq.size() != 0) || s_valid);
    if (s_valid) begin
      chk("wb_result", bus.wb_result, s_ent.result);
      chk("wb_pipe", bus.wb_pipe, s_ent.pipe);
      chk("wb_src", bus.wb_src, s_src);
    end
    if (bus.wb_valid && rdy) begin
      acc.push_back(bus.wb_result);
      acc_src.push_back(bus.wb_src);
    end
    mul_taken = mv && !exp_stall && !fl;
    div_taken = take_div;
    if (fl) begin
      mq.delete();
      s_valid = 1'b0;
      starve  = 0;
    end else begin
      e = '0;
      if (take_mul) e = mq.pop_front();
      if (mv && !exp_stall) mq.push_back('{pipe: mp, result: mres});
      if (ld) begin
        s_valid = take_mul || take_div;
        if (take_div) begin
          s_ent = '{pipe: dp, result: dres};
          s_src = 1'b1;
        end else if (take_mul) begin
          s_ent = e;
          s_src = 1'b0;
        end
      end
      if (dv && !take_div) starve = (starve < Limit) ? starve + 1 : Limit;
      else starve = 0;
    end
  endtask

  task automatic idle(input logic rdy);
    logic mt, dt;
    cycle(1'b0, 32'h0, '0, 1'b0, 32'h0, '0, rdy, 1'b0, mt, dt);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".wb_valid"}, bus.wb_valid, 1'b0);
    chk({tag, ".wb_pipe"}, bus.wb_pipe, 8'h0);
    chk({tag, ".wb_result"}, bus.wb_result, 32'h0);
    chk({tag, ".wb_src"}, bus.wb_src, 1'b0);
    chk({tag, ".mul_stall"}, bus.mul_stall, 1'b0);
    chk({tag, ".div_ready"}, bus.div_ready, 1'b0);
    chk({tag, ".busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        mt, dt, m_pend, d_pend, rdy, fl;
    logic [31:0] m_val, d_val, exp_list[$];
    logic [4:0]  m_rd, d_rd;
    int          k, lost, first_stall, c;

    // Table: single MUL, div only, simultaneous arrival (wb_ready held high).
    //          mv mres    mrd dv dres    drd  val res     src rd dr busy
    tbl[0]  = '{0, 32'h0,  0,  0, 32'h0,  0,   0, 32'h0,  0,  0, 0, 0};
    tbl[1]  = '{1, 32'h6,  5,  0, 32'h0,  0,   0, 32'h0,  0,  0, 0, 0};
    tbl[2]  = '{0, 32'h0,  0,  0, 32'h0,  0,   0, 32'h0,  0,  0, 0, 1};
    tbl[3]  = '{0, 32'h0,  0,  0, 32'h0,  0,   1, 32'h6,  0,  5, 0, 1};
    tbl[4]  = '{0, 32'h0,  0,  0, 32'h0,  0,   0, 32'h0,  0,  0, 0, 0};
    tbl[5]  = '{0, 32'h0,  0,  1, 32'h7,  9,   0, 32'h0,  0,  0, 1, 0};
    tbl[6]  = '{0, 32'h0,  0,  0, 32'h0,  0,   1, 32'h7,  1,  9, 0, 1};
    tbl[7]  = '{0, 32'h0,  0,  0, 32'h0,  0,   0, 32'h0,  0,  0, 0, 0};
    tbl[8]  = '{1, 32'h11, 1,  1, 32'h22, 2,   0, 32'h0,  0,  0, 1, 0};
    tbl[9]  = '{0, 32'h0,  0,  0, 32'h0,  0,   1, 32'h22, 1,  2, 0, 1};
    tbl[10] = '{0, 32'h0,  0,  0, 32'h0,  0,   1, 32'h11, 0,  1, 0, 1};
    tbl[11] = '{0, 32'h0,  0,  0, 32'h0,  0,   0, 32'h0,  0,  0, 0, 0};

    bus.mul_valid = 1'b0; bus.mul_result = '0; bus.mul_pipe = '0;
    bus.div_valid = 1'b1; bus.div_result = '0; bus.div_pipe = '0;
    bus.wb_ready  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    bus.div_valid = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].mv, tbl[i].mres, pipe_of(tbl[i].mrd), tbl[i].dv, tbl[i].dres,
            pipe_of(tbl[i].drd), 1'b1, 1'b0, mt, dt);
      chk($sformatf("tbl[%0d].wb_valid", i), bus.wb_valid, tbl[i].e_valid);
      chk($sformatf("tbl[%0d].div_ready", i), bus.div_ready, tbl[i].e_dr);
      chk($sformatf("tbl[%0d].busy", i), bus.busy, tbl[i].e_busy);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl[%0d].wb_result", i), bus.wb_result, tbl[i].e_res);
        chk($sformatf("tbl[%0d].wb_src", i), bus.wb_src, tbl[i].e_src);
        chk($sformatf("tbl[%0d].wb_rd", i), bus.wb_pipe.rd, tbl[i].e_rd);
      end
    end

    // Backpressure fill: results 1..6 with wb_ready low, then released.
    acc.delete(); acc_src.delete();
    k = 1; first_stall = -1;
    for (c = 0; c < 40 && acc.size() < 6; c++) begin
      cycle(k <= 6, 32'(k), pipe_of(5'(k)), 1'b0, 32'h0, '0, c >= 8, 1'b0, mt, dt);
      if (bus.mul_stall && first_stall < 0) first_stall = c;
      if (mt) k++;
    end
    chk("bp.first_stall_cycle", first_stall, 5);
    chk("bp.count", acc.size(), 6);
    for (int i = 0; i < acc.size(); i++) chk($sformatf("bp.order[%0d]", i), acc[i], i + 1);
    idle(1'b1);

    // Starvation: div waits behind a continuously refilled FIFO.
    acc.delete(); acc_src.delete();
    k = 0; lost = 0; d_pend = 1'b1;
    cycle(1'b1, 32'h100, pipe_of(5'd10), 1'b0, 32'h0, '0, 1'b1, 1'b0, mt, dt);
    k = 1;
    for (c = 0; c < 12 && d_pend; c++) begin
      cycle(1'b1, 32'h100 + 32'(k), pipe_of(5'd10), 1'b1, 32'hFFFF_FFFF, pipe_of(5'd20),
            1'b1, 1'b0, mt, dt);
      if (mt) k++;
      if (dt) d_pend = 1'b0;
      else lost++;
    end
    chk("starve.accepted", d_pend, 1'b0);
    chk("starve.lost_cycles", lost, Limit);
    while (k < 8) begin
      cycle(1'b1, 32'h100 + 32'(k), pipe_of(5'd10), 1'b0, 32'h0, '0, 1'b1, 1'b0, mt, dt);
      if (mt) k++;
    end
    repeat (8) idle(1'b1);
    exp_list = '{32'h100, 32'h101, 32'h102, 32'hFFFF_FFFF, 32'h103, 32'h104, 32'h105,
                 32'h106, 32'h107};
    chk("starve.count", acc.size(), exp_list.size());
    for (int i = 0; i < acc.size() && i < exp_list.size(); i++)
      chk($sformatf("starve.order[%0d]", i), acc[i], exp_list[i]);
    if (acc_src.size() > 3) chk("starve.div_src", acc_src[3], 1'b1);

    // Flush: three queued, slot full, flush with a concurrent mul_valid.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h201 + 32'(i), pipe_of(5'd3), 1'b0, 32'h0, '0, 1'b0, 1'b0, mt, dt);
    cycle(1'b1, 32'h205, pipe_of(5'd3), 1'b0, 32'h0, '0, 1'b0, 1'b1, mt, dt);
    chk("flush.pre_wb_valid", bus.wb_valid, 1'b1);
    idle(1'b1);
    chk("flush.wb_valid", bus.wb_valid, 1'b0);
    chk("flush.mul_stall", bus.mul_stall, 1'b0);
    chk("flush.busy", bus.busy, 1'b0);
    idle(1'b1);
    chk("flush.no_capture", bus.busy, 1'b0);
    cycle(1'b0, 32'h0, '0, 1'b1, 32'h33, pipe_of(5'd4), 1'b1, 1'b1, mt, dt);
    chk("flush.div_ready_forced", bus.div_ready, 1'b0);
    cycle(1'b0, 32'h0, '0, 1'b1, 32'h33, pipe_of(5'd4), 1'b1, 1'b0, mt, dt);
    chk("flush.div_after", bus.div_ready, 1'b1);
    idle(1'b1);

    // Random traffic under protocol: held payloads until accepted, rare flushes.
    m_pend = 1'b0; d_pend = 1'b0;
    m_val = '0; d_val = '0; m_rd = '0; d_rd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!m_pend && $urandom_range(9) < 6) begin
        m_pend = 1'b1; m_val = $urandom; m_rd = 5'($urandom);
      end
      if (!d_pend && $urandom_range(9) < 3) begin
        d_pend = 1'b1; d_val = $urandom; d_rd = 5'($urandom);
      end
      rdy = ($urandom_range(9) < 6);
      fl  = ($urandom_range(63) == 0);
      cycle(m_pend, m_val, pipe_of(m_rd), d_pend, d_val, pipe_of(d_rd), rdy, fl, mt, dt);
      if (mt || fl) m_pend = 1'b0;
      if (dt || fl) d_pend = 1'b0;
    end
    repeat (8) idle(1'b1);

    // Asynchronous reset mid-burst, then nominal 2-cycle MUL latency.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h300 + 32'(i), pipe_of(5'd6), 1'b0, 32'h0, '0, 1'b0, 1'b0, mt, dt);
    @(posedge clk);
    #3;
    bus.div_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    bus.div_valid = 1'b0;
    bus.mul_valid = 1'b0;
    reset_n = 1'b1;
    cycle(1'b1, 32'h77, pipe_of(5'd3), 1'b0, 32'h0, '0, 1'b1, 1'b0, mt, dt);
    idle(1'b1);
    chk("post_reset.t1_wb_valid", bus.wb_valid, 1'b0);
    idle(1'b1);
    chk("post_reset.t2_wb_valid", bus.wb_valid, 1'b1);
    chk("post_reset.t2_wb_result", bus.wb_result, 32'h77);
    chk("post_reset.t2_wb_rd", bus.wb_pipe.rd, 5'd3);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
